// File: rtl/score_digit_sequencer.sv
// rtl/score_digit_sequencer.sv - binary-to-BCD digit sequencer feeding a tile digit renderer
// Serial double-dabble conversion, frame-synchronous display swap, per-pixel digit lookup.
module score_digit_sequencer #(
  parameter int VALUE_W  = 14,
  parameter int NDIGITS  = 4,
  parameter int X_TILE   = 0,
  parameter int LZ_BLANK = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [VALUE_W-1:0] i_value,
  input  logic               i_value_valid,
  output logic               o_value_ready,
  output logic               o_busy,
  input  logic               i_frame_start,
  input  logic [9:0]         i_hpos,
  input  logic               i_visible,
  output logic [3:0]         o_digit,
  output logic               o_digit_on,
  output logic               o_pending
);

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int         BW   = 4 * NDIGITS;
  localparam int         CW   = $clog2(VALUE_W + 1);
  localparam int         MAXV = pow10(NDIGITS) - 1;
  localparam logic [5:0] XT   = 6'(X_TILE);
  localparam logic [5:0] ND   = 6'(NDIGITS);

  typedef enum logic {IDLE, CONV} state_t;

  state_t             state, state_nxt;
  logic               accept, done;
  logic [VALUE_W-1:0] cap, bin, bin_nxt;
  logic [BW-1:0]      bcd, bcd_adj, bcd_nxt;
  logic [BW-1:0]      pend_buf, disp_buf;
  logic [CW-1:0]      cnt;
  logic               pending;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    o_value_ready = 1'b0;
    o_busy        = 1'b0;
    accept        = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        o_value_ready = 1'b1;
        if (i_value_valid) begin
          accept    = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        o_busy = 1'b1;
        if (cnt == CW'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Values beyond the displayable range clamp to all nines.
  always_comb begin
    cap = i_value;
    if (32'(i_value) > MAXV) cap = VALUE_W'(MAXV);
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NDIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    {bcd_nxt, bin_nxt} = {bcd_adj, bin} << 1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bin      <= '0;
      bcd      <= '0;
      cnt      <= '0;
      pend_buf <= '0;
      disp_buf <= '0;
      pending  <= 1'b0;
    end else begin
      if (accept) begin
        bin <= cap;
        bcd <= '0;
        cnt <= CW'(VALUE_W);
      end else if (state == CONV) begin
        bin <= bin_nxt;
        bcd <= bcd_nxt;
        cnt <= cnt - CW'(1);
      end
      // Swap sees the pre-edge pending state; a same-cycle completion waits a frame.
      if (i_frame_start && pending) begin
        disp_buf <= pend_buf;
        pending  <= 1'b0;
      end
      if (done) begin
        pend_buf <= bcd_nxt;
        pending  <= 1'b1;
      end
    end
  end

  assign o_pending = pending;

  logic [5:0]         tile, k;
  logic               in_range, run, sel_lz, on_nxt;
  logic [NDIGITS-1:0] lz;
  logic [3:0]         sel_digit, digit_nxt;

  assign tile     = i_hpos[9:4];
  assign k        = tile - XT;
  assign in_range = (tile >= XT) && (k < ND);

  // lz[j] marks digit j (j=0 most significant) as part of the leading-zero run.
  always_comb begin
    run = 1'b1;
    lz  = '0;
    for (int j = 0; j < NDIGITS; j++) begin
      run   = run && (disp_buf[(NDIGITS-1-j)*4 +: 4] == 4'd0);
      lz[j] = run;
    end
  end

  always_comb begin
    sel_digit = 4'd0;
    sel_lz    = 1'b0;
    for (int j = 0; j < NDIGITS; j++) begin
      if (k == 6'(j)) begin
        sel_digit = disp_buf[(NDIGITS-1-j)*4 +: 4];
        sel_lz    = lz[j];
      end
    end
    digit_nxt = in_range ? sel_digit : 4'd0;
    on_nxt    = i_visible && in_range &&
                !((LZ_BLANK != 0) && sel_lz && (k != ND - 6'd1));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_digit    <= 4'd0;
      o_digit_on <= 1'b0;
    end else begin
      o_digit    <= digit_nxt;
      o_digit_on <= on_nxt;
    end
  end

endmodule

// File: tb/tb_score_digit_sequencer.sv
// tb/tb_score_digit_sequencer.sv - scoreboard bench for score_digit_sequencer
// Two instances share stimulus: leading-zero blanking on (a) and off (b).
module tb_score_digit_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] value = '0;
  logic        valid = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  hpos = '0;
  logic        visible = 1'b0;

  logic        ready_a, busy_a, pend_a, on_a;
  logic [3:0]  digit_a;
  logic        ready_b, busy_b, pend_b, on_b;
  logic [3:0]  digit_b;

  int checks = 0;
  int failures = 0;

  int disp_m[4];
  int pend_m[4];
  bit pflag_m;
  logic [9:0] sb_q[$];
  int offs[3] = '{0, 7, 15};

  score_digit_sequencer #(.VALUE_W(14), .NDIGITS(4), .X_TILE(0), .LZ_BLANK(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_value_valid(valid),
    .o_value_ready(ready_a), .o_busy(busy_a), .i_frame_start(frame_start),
    .i_hpos(hpos), .i_visible(visible), .o_digit(digit_a), .o_digit_on(on_a),
    .o_pending(pend_a)
  );

  score_digit_sequencer #(.VALUE_W(14), .NDIGITS(4), .X_TILE(0), .LZ_BLANK(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_value(value), .i_value_valid(valid),
    .o_value_ready(ready_b), .o_busy(busy_b), .i_frame_start(frame_start),
    .i_hpos(hpos), .i_visible(visible), .o_digit(digit_b), .o_digit_on(on_b),
    .o_pending(pend_b)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic set_pend(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    pend_m[0] = s / 1000;
    pend_m[1] = (s / 100) % 10;
    pend_m[2] = (s / 10) % 10;
    pend_m[3] = s % 10;
    pflag_m = 1'b1;
  endtask

  function automatic logic [4:0] exp_px(input int tile, input bit vis, input bit lzb);
    bit lead;
    if (tile > 3) return 5'd0;
    lead = 1'b1;
    for (int j = 0; j <= tile; j++) if (disp_m[j] != 0) lead = 1'b0;
    return {vis && !(lzb && lead && tile != 3), 4'(disp_m[tile])};
  endfunction

  task automatic compare_px();
    logic [9:0] e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb_q.pop_front();
    check("px_a_on", on_a, e[9]);
    check("px_a_digit", digit_a, e[8:5]);
    check("px_b_on", on_b, e[4]);
    check("px_b_digit", digit_b, e[3:0]);
  endtask

  task automatic drive_px(input int h, input bit vis);
    @(posedge clk); #1;
    if (sb_q.size() > 0) compare_px();
    hpos = 10'(h);
    visible = vis;
    sb_q.push_back({exp_px(h / 16, vis, 1'b1), exp_px(h / 16, vis, 1'b0)});
  endtask

  task automatic sweep();
    for (int t = 0; t < 7; t++)
      for (int o = 0; o < 3; o++) drive_px(t * 16 + offs[o], 1'b1);
    drive_px(48, 1'b0);
    @(posedge clk); #1;
    compare_px();
  endtask

  task automatic frame();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    if (pflag_m) begin
      disp_m = pend_m;
      pflag_m = 1'b0;
    end
    check("pending_after_frame", pend_a, pflag_m);
  endtask

  task automatic send(input int v, input bit junk);
    int n;
    int busy_n;
    n = 0;
    @(posedge clk); #1;
    while (!ready_a && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_before_send", ready_a, 1);
    value = 14'(v);
    valid = 1'b1;
    @(posedge clk); #1;
    if (junk) value = 14'd42;
    else valid = 1'b0;
    busy_n = 0;
    while (busy_a && busy_n < 100) begin
      busy_n++;
      if (busy_n == 8) valid = 1'b0;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check("busy_cycles", busy_n, 14);
    check("pending_set", pend_a, 1);
    check("ready_after_conv", ready_a, 1);
    set_pend(v);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      disp_m[i] = 0;
      pend_m[i] = 0;
    end
    pflag_m = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_pending", pend_a, 0);
    check("rst_digit", digit_a, 0);
    check("rst_digit_on", on_a, 0);
    rst_n = 1'b1;

    frame();
    sweep();

    send(1234, 1'b0);
    sweep();
    frame();
    sweep();

    send(7, 1'b0);
    frame();
    sweep();

    send(12000, 1'b0);
    frame();
    sweep();
    send(10000, 1'b0);
    frame();
    sweep();
    send(9999, 1'b0);
    frame();
    sweep();

    send(1234, 1'b1);
    frame();
    sweep();
    frame();
    sweep();

    // Completion lands on the strobe cycle: the older pending value is swapped instead.
    send(4321, 1'b0);
    @(posedge clk); #1;
    value = 14'd5678;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check("busy_last_cycle", busy_a, 1);
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    if (pflag_m) begin
      disp_m = pend_m;
      pflag_m = 1'b0;
    end
    set_pend(5678);
    check("coincide_busy", busy_a, 0);
    check("coincide_pending", pend_a, 1);
    sweep();
    frame();
    sweep();

    @(posedge clk); #1;
    value = 14'd555;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midconv_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("rstconv_busy", busy_a, 0);
    check("rstconv_ready", ready_a, 1);
    check("rstconv_pending", pend_a, 0);
    check("rstconv_digit", digit_a, 0);
    check("rstconv_digit_on", on_a, 0);
    for (int i = 0; i < 4; i++) begin
      disp_m[i] = 0;
      pend_m[i] = 0;
    end
    pflag_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rstconv_no_result", pend_a, 0);
    frame();
    sweep();
    send(321, 1'b0);
    frame();
    sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
